// File: rtl/riscv_pkg.sv
// Shared RISC-V execute-stage definitions: ALU operation codes, branch
// condition codes (funct3) and forwarding-select encodings.
package riscv_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_EXM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU. Shifts use only the low five bits of b;
// unrecognised operation codes produce zero.
module alu
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] result
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  // Operation select
  always_comb begin
    result = '0;
    case (alu_ctrl)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_ADD:  result = a + b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SUB:  result = a - b;
      ALU_SRA:  result = $signed(a) >>> shamt;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution and the
// EX/MEM pipeline register. Define EX_STAGE_FWD_EN to compile operand
// forwarding in; without it the forwarding ports are present but ignored.
module ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            stall,
  input  logic            flush,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  input  logic            alu_src,
  input  logic            is_branch,
  input  logic [2:0]      funct3,
  input  logic [4:0]      rd,
  input  logic            reg_write,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [1:0]      fwd_a_sel,
  input  logic [1:0]      fwd_b_sel,
  input  logic [XLEN-1:0] wb_fwd_data,
  output logic            exm_valid,
  output logic [XLEN-1:0] exm_alu_result,
  output logic [XLEN-1:0] exm_store_data,
  output logic [4:0]      exm_rd,
  output logic            exm_reg_write,
  output logic            exm_mem_read,
  output logic            exm_mem_write,
  output logic            exm_br_taken,
  output logic [XLEN-1:0] exm_br_target
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] alu_result_q, alu_result_d;
  logic [XLEN-1:0] store_data_q, store_data_d;
  logic [4:0]      rd_q, rd_d;
  logic            reg_write_q, reg_write_d;
  logic            mem_read_q, mem_read_d;
  logic            mem_write_q, mem_write_d;
  logic            br_taken_q, br_taken_d;
  logic [XLEN-1:0] br_target_q, br_target_d;

  logic [XLEN-1:0] op_a, op_b_fwd, op_b, alu_out;
  logic            br_cond;

`ifdef EX_STAGE_FWD_EN
  // Forwarding muxes; EX/MEM source is the registered result already in flight
  always_comb begin
    op_a = rs1_data;
    case (fwd_a_sel)
      FWD_EXM: op_a = alu_result_q;
      FWD_WB:  op_a = wb_fwd_data;
      default: op_a = rs1_data;
    endcase
    op_b_fwd = rs2_data;
    case (fwd_b_sel)
      FWD_EXM: op_b_fwd = alu_result_q;
      FWD_WB:  op_b_fwd = wb_fwd_data;
      default: op_b_fwd = rs2_data;
    endcase
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_a_sel, fwd_b_sel, wb_fwd_data};
  assign op_a       = rs1_data;
  assign op_b_fwd   = rs2_data;
`endif

  assign op_b = alu_src ? imm : op_b_fwd;

  alu #(.XLEN(XLEN)) u_alu (
    .a        (op_a),
    .b        (op_b),
    .alu_ctrl (alu_ctrl),
    .result   (alu_out)
  );

  // Branch condition on forwarded register operands
  always_comb begin
    br_cond = 1'b0;
    case (funct3)
      F3_BEQ:  br_cond = (op_a == op_b_fwd);
      F3_BNE:  br_cond = (op_a != op_b_fwd);
      F3_BLT:  br_cond = ($signed(op_a) <  $signed(op_b_fwd));
      F3_BGE:  br_cond = ($signed(op_a) >= $signed(op_b_fwd));
      F3_BLTU: br_cond = (op_a <  op_b_fwd);
      F3_BGEU: br_cond = (op_a >= op_b_fwd);
      default: br_cond = 1'b0;
    endcase
  end

  // EX/MEM next state: flush beats stall; an empty slot loads a bubble
  always_comb begin
    valid_d      = valid_q;
    alu_result_d = alu_result_q;
    store_data_d = store_data_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    br_taken_d   = br_taken_q;
    br_target_d  = br_target_q;
    if (flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      br_taken_d  = 1'b0;
    end else if (!stall) begin
      valid_d      = in_valid;
      alu_result_d = alu_out;
      store_data_d = op_b_fwd;
      rd_d         = rd;
      reg_write_d  = in_valid & reg_write;
      mem_read_d   = in_valid & mem_read;
      mem_write_d  = in_valid & mem_write;
      br_taken_d   = in_valid & is_branch & br_cond;
      br_target_d  = pc + imm;
    end
  end

  // EX/MEM register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      alu_result_q <= '0;
      store_data_q <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      br_taken_q   <= 1'b0;
      br_target_q  <= '0;
    end else begin
      valid_q      <= valid_d;
      alu_result_q <= alu_result_d;
      store_data_q <= store_data_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      br_taken_q   <= br_taken_d;
      br_target_q  <= br_target_d;
    end
  end

  assign exm_valid      = valid_q;
  assign exm_alu_result = alu_result_q;
  assign exm_store_data = store_data_q;
  assign exm_rd         = rd_q;
  assign exm_reg_write  = reg_write_q;
  assign exm_mem_read   = mem_read_q;
  assign exm_mem_write  = mem_write_q;
  assign exm_br_taken   = br_taken_q;
  assign exm_br_target  = br_target_q;

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1, the ID/EX slot holds a real instruction.
REQ-005 SHALL have port stall, input, 1, hold the EX/MEM register.
REQ-006 SHALL have port flush, input, 1, load a bubble into EX/MEM.
REQ-007 SHALL have port alu_ctrl, input, 4, ALU operation code from the ALU control decode.
REQ-008 SHALL have ports rs1_data, rs2_data, imm and pc, input, XLEN each, the operands.
REQ-009 SHALL have port alu_src, input, 1, ALU B operand select: 1 selects imm, 0 selects rs2.
REQ-010 SHALL have ports is_branch, input, 1, and funct3, input, 3, branch qualifier and condition.
REQ-011 SHALL have ports rd, input, 5, and reg_write, mem_read, mem_write, input, 1 each, control passed through to EX/MEM.
REQ-012 SHALL have ports fwd_a_sel and fwd_b_sel, input, 2 each, and wb_fwd_data, input, XLEN, the forwarding controls and WB data.
REQ-013 SHALL have outputs exm_valid (1), exm_alu_result (XLEN), exm_store_data (XLEN), exm_rd (5), exm_reg_write, exm_mem_read and exm_mem_write (1 each), all registered.
REQ-014 SHALL have outputs exm_br_taken (1) and exm_br_target (XLEN), registered branch redirect.

Function
REQ-015 SHALL decode alu_ctrl as: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SRA, 1000 SLT (signed), 1001 SLTU; any other code yields result 0.
REQ-016 SHALL use shift amount B[4:0] only; arithmetic wraps modulo 2^32; SLT and SLTU yield 0 or 1 zero-extended.
REQ-017 SHALL set ALU A to the forwarded rs1 value and ALU B to alu_src ? imm : the forwarded rs2 value; exm_store_data SHALL be the forwarded rs2 value.
REQ-018 SHALL evaluate the branch on the forwarded rs1/rs2 by funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010 and 011 never taken.
REQ-019 SHALL compute exm_br_target = pc + imm (wrapping) and exm_br_taken = in_valid & is_branch & condition.
REQ-020 SHALL have latency of exactly 1 cycle: inputs sampled at edge N appear on the exm_* outputs after edge N.
REQ-021 SHALL, on flush, clear exm_valid, exm_reg_write, exm_mem_read, exm_mem_write and exm_br_taken; the data fields are don't-care.
REQ-022 SHALL, on stall without flush, hold every exm_* register unchanged.
REQ-023 SHALL give flush priority over stall when both are asserted.
REQ-024 SHALL, when in_valid=0 and neither flush nor stall is asserted, load a bubble as in REQ-021.

Reset
REQ-025 SHALL drive every exm_* output to 0 while rst_n=0, independent of clk, including mid-stall.
REQ-026 SHALL, on the first edge after rst_n deasserts, behave per REQ-020..024.

Configuration
REQ-027 SHALL use macro EX_STAGE_FWD_EN to compile forwarding in or out.
REQ-028 SHALL, with EX_STAGE_FWD_EN defined, select each forwarded operand by sel: 00 register data, 01 current exm_alu_result, 10 wb_fwd_data, 11 register data.
REQ-029 SHALL, without EX_STAGE_FWD_EN, keep the fwd_a_sel, fwd_b_sel and wb_fwd_data ports but ignore them, so forwarded operands equal rs1_data and rs2_data.

Structure
REQ-030 SHALL take the ALU operation enum (4-bit codes of REQ-015) and the branch funct3 constants from shared package riscv_pkg.
REQ-031 SHALL implement the ALU as combinational sub-module alu (a, b, alu_ctrl -> result), instantiated once.

Verification
REQ-032 SHALL cover: rs1=0x7FFFFFFF, imm=1, alu_src=1, alu_ctrl=0010 -> next cycle exm_alu_result=0x80000000, exm_valid=1.
REQ-033 SHALL cover: rs1=0x80000000, rs2=4, SRA then SRL -> 0xF8000000 then 0x08000000; SLT(-1,1)=1, SLTU(-1,1)=0.
REQ-034 SHALL cover: is_branch=1, funct3=100, rs1=-2, rs2=1, pc=0x100, imm=-8 -> exm_br_taken=1, exm_br_target=0xF8.
REQ-035 SHALL cover: stall=1 for 3 cycles with changing inputs -> exm_* constant; stall=flush=1 -> exm_valid=0, exm_br_taken=0.
REQ-036 SHALL cover (FWD_EN): prior result 0x10 in EX/MEM, fwd_a_sel=01, ADD imm 4 -> 0x14; fwd_b_sel=10, wb_fwd_data=0x55, store -> exm_store_data=0x55.
REQ-037 SHALL cover: rst_n low mid-stream between clock edges -> all exm_* go to 0 immediately.
